// File: rtl/ship_ctrl_if.sv
// Shot request handshake between the ship controller and the bullet engine.
// Ports: shot_valid/shot_x from the ship side, shot_ready from the bullet side.

interface ship_ctrl_if;
   logic        shot_valid;
   logic        shot_ready;
   logic [15:0] shot_x;

   modport master (
      output shot_valid,
      output shot_x,
      input  shot_ready
   );

   modport slave (
      input  shot_valid,
      input  shot_x,
      output shot_ready
   );
endinterface

// File: rtl/ship_ctrl.sv
// Per-frame ship motion from accelerometer tilt, plus one-shot fire control.
// Ports: clk_pix/rst, frame pulse, tilt_x/tilt_valid, fire, ship_x, busy,
//        shot (valid/ready/x handshake to the bullet engine).

module ship_ctrl #(
   parameter int SCREEN_W   = 640,
   parameter int SHIP_WIDTH = 17,
   parameter int X_INIT     = 220,
   parameter int DEADZONE   = 16,
   parameter int SHIFT      = 4,
   parameter int MAX_STEP   = 8,
   parameter int COOLDOWN   = 15
) (
   input  logic               clk_pix,
   input  logic               rst,
   input  logic               frame,
   input  logic signed [11:0] tilt_x,
   input  logic               tilt_valid,
   input  logic               fire,
   output logic [15:0]        ship_x,
   output logic               busy,
   ship_ctrl_if.master        shot
);

   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   localparam logic signed [12:0] DZ      = 13'(DEADZONE);
   localparam logic signed [11:0] STEP_HI = 12'(MAX_STEP);
   localparam logic signed [11:0] STEP_LO = -12'(MAX_STEP);
   localparam logic signed [16:0] X_MAX   = 17'(SCREEN_W - SHIP_WIDTH);
   localparam logic [15:0]        X_RST   = 16'(X_INIT);
   localparam logic [15:0]        X_MID   = 16'(SHIP_WIDTH / 2);
   localparam logic [CW-1:0]      CD_LOAD = CW'(COOLDOWN);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      MOVE
   } state_t;

   state_t state_q, state_d;

   logic signed [11:0] tilt_q, tilt_d;
   logic signed [11:0] step_q, step_d;
   logic [15:0]        ship_x_q, ship_x_d;
   logic               fire_q, fire_d;
   logic               shot_valid_q, shot_valid_d;
   logic [15:0]        shot_x_q, shot_x_d;
   logic [CW-1:0]      cd_q, cd_d;

   logic signed [12:0] tilt_ext;
   logic signed [12:0] tilt_mag;
   logic signed [11:0] tilt_shr;
   logic signed [16:0] nx;
   logic               fire_edge;

   // Motion path: tilt latch and the IDLE -> CALC -> MOVE update.
   always_comb begin
      tilt_d   = tilt_valid ? tilt_x : tilt_q;
      state_d  = state_q;
      step_d   = step_q;
      ship_x_d = ship_x_q;

      // 13-bit magnitude so that -2048 does not wrap.
      tilt_ext = {tilt_q[11], tilt_q};
      tilt_mag = tilt_ext[12] ? -tilt_ext : tilt_ext;
      tilt_shr = tilt_q >>> SHIFT;

      nx = $signed({1'b0, ship_x_q}) + $signed({{5{step_q[11]}}, step_q});

      unique case (state_q)
         IDLE: begin
            if (frame) state_d = CALC;
         end
         CALC: begin
            if (tilt_mag < DZ)          step_d = '0;
            else if (tilt_shr > STEP_HI) step_d = STEP_HI;
            else if (tilt_shr < STEP_LO) step_d = STEP_LO;
            else                         step_d = tilt_shr;
            state_d = MOVE;
         end
         MOVE: begin
            if (nx < 0)          ship_x_d = '0;
            else if (nx > X_MAX) ship_x_d = X_MAX[15:0];
            else                 ship_x_d = nx[15:0];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Fire path: edge detect, accept, handshake and frame-based cooldown.
   always_comb begin
      fire_d       = fire;
      fire_edge    = fire & ~fire_q;
      shot_valid_d = shot_valid_q;
      shot_x_d     = shot_x_q;
      cd_d         = cd_q;

      if (frame && cd_q != '0) cd_d = cd_q - 1'b1;

      // A completed transfer reloads cooldown, overriding any frame decrement.
      if (shot_valid_q && shot.shot_ready) begin
         shot_valid_d = 1'b0;
         cd_d         = CD_LOAD;
      end else if (fire_edge && !shot_valid_q && cd_q == '0) begin
         shot_valid_d = 1'b1;
         shot_x_d     = ship_x_q + X_MID;
      end
   end

   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tilt_q       <= '0;
         step_q       <= '0;
         ship_x_q     <= X_RST;
         fire_q       <= 1'b1;
         shot_valid_q <= 1'b0;
         shot_x_q     <= '0;
         cd_q         <= '0;
      end else begin
         state_q      <= state_d;
         tilt_q       <= tilt_d;
         step_q       <= step_d;
         ship_x_q     <= ship_x_d;
         fire_q       <= fire_d;
         shot_valid_q <= shot_valid_d;
         shot_x_q     <= shot_x_d;
         cd_q         <= cd_d;
      end
   end

   assign ship_x          = ship_x_q;
   assign busy            = (state_q != IDLE);
   assign shot.shot_valid = shot_valid_q;
   assign shot.shot_x     = shot_x_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// Directed bench for ship_ctrl: motion, clamping, shot handshake, cooldown.
// Expected values are hand-computed constants.

module tb_ship_ctrl;

   logic               clk_pix = 1'b0;
   logic               rst;
   logic               frame;
   logic signed [11:0] tilt_x;
   logic               tilt_valid;
   logic               fire;
   logic [15:0]        ship_x;
   logic               busy;

   int n_chk  = 0;
   int n_pass = 0;

   ship_ctrl_if sif ();

   ship_ctrl dut (
      .clk_pix    (clk_pix),
      .rst        (rst),
      .frame      (frame),
      .tilt_x     (tilt_x),
      .tilt_valid (tilt_valid),
      .fire       (fire),
      .ship_x     (ship_x),
      .busy       (busy),
      .shot       (sif.master)
   );

   always #20 clk_pix = ~clk_pix;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   // Full frame update with a given tilt; checks busy profile and final x.
   task automatic do_frame(input int t, input int exp_x, input bit chk_busy);
      tilt_x     = 12'(t);
      tilt_valid = 1'b1;
      frame      = 1'b1;
      tick();
      frame      = 1'b0;
      tilt_valid = 1'b0;
      if (chk_busy) check("busy_t", int'(busy), 1);
      tick();
      if (chk_busy) check("busy_t1", int'(busy), 1);
      tick();
      if (chk_busy) check("busy_t2", int'(busy), 0);
      check("ship_x", int'(ship_x), exp_x);
   endtask

   task automatic fire_pulse(input string tag, input int exp_v);
      fire = 1'b1;
      tick();
      check(tag, int'(sif.shot_valid), exp_v);
      fire = 1'b0;
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      frame          = 1'b0;
      tilt_x         = '0;
      tilt_valid     = 1'b0;
      fire           = 1'b1;
      sif.shot_ready = 1'b0;
      tick();
      tick();
      #5 rst = 1'b0;
      check("rst_x", int'(ship_x), 220);
      check("rst_valid", int'(sif.shot_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_shot_x", int'(sif.shot_x), 0);
      for (int i = 0; i < 3; i++) tick();
      check("held_fire", int'(sif.shot_valid), 0);

      // Shot handshake with ready held low.
      fire = 1'b0;
      tick();
      fire = 1'b1;
      tick();
      check("shot_valid", int'(sif.shot_valid), 1);
      check("shot_x", int'(sif.shot_x), 228);
      fire = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fire = (i == 2);
         tick();
         check("hold_valid", int'(sif.shot_valid), 1);
         check("hold_x", int'(sif.shot_x), 228);
      end
      fire = 1'b0;
      sif.shot_ready = 1'b1;
      tick();
      check("hs_clear", int'(sif.shot_valid), 0);
      check("hs_x_keep", int'(sif.shot_x), 228);

      // Cooldown of 15 frames.
      do_frame(0, 220, 1'b0);
      fire_pulse("cd_1", 0);
      for (int i = 0; i < 13; i++) do_frame(0, 220, 1'b0);
      fire_pulse("cd_14", 0);
      do_frame(0, 220, 1'b0);
      fire_pulse("cd_15", 1);
      check("cd_1cyc", int'(sif.shot_valid), 0);

      // Tilt to step conversion.
      do_frame(80, 225, 1'b1);
      do_frame(10, 225, 1'b0);
      do_frame(-400, 217, 1'b0);
      do_frame(-20, 215, 1'b0);

      // Right clamp.
      for (int i = 0; i < 50; i++) do_frame(128, 215 + 8 * (i + 1), 1'b0);
      do_frame(80, 620, 1'b0);
      do_frame(200, 623, 1'b0);
      do_frame(200, 623, 1'b0);

      // Left clamp.
      for (int i = 0; i < 77; i++) do_frame(-128, 623 - 8 * (i + 1), 1'b0);
      do_frame(-64, 3, 1'b0);
      do_frame(-128, 0, 1'b0);
      do_frame(-2048, 0, 1'b0);

      // Fire on the MOVE edge uses the pre-update position.
      rst = 1'b1;
      fire = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      do_frame(80, 225, 1'b0);
      tilt_x     = 12'sd80;
      tilt_valid = 1'b1;
      frame      = 1'b1;
      tick();
      frame      = 1'b0;
      tilt_valid = 1'b0;
      tick();
      fire = 1'b1;
      tick();
      fire = 1'b0;
      check("sim_x", int'(ship_x), 230);
      check("sim_valid", int'(sif.shot_valid), 1);
      check("sim_shot_x", int'(sif.shot_x), 233);
      tick();

      // Asynchronous reset while in MOVE.
      tilt_x     = 12'sd80;
      tilt_valid = 1'b1;
      frame      = 1'b1;
      tick();
      frame      = 1'b0;
      tilt_valid = 1'b0;
      tick();
      check("pre_rst_busy", int'(busy), 1);
      #5 rst = 1'b1;
      #1;
      check("arst_x", int'(ship_x), 220);
      check("arst_busy", int'(busy), 0);
      check("arst_valid", int'(sif.shot_valid), 0);
      tick();
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ship_ctrl.md
# ship_ctrl

Per-frame motion and fire controller for the player spaceship sprite. It latches accelerometer tilt samples and, once per display frame, converts the latest sample into a saturated horizontal step and applies it to the ship position, clamped to the screen. It also turns the fire push-button into a one-shot, cooldown-limited shot request for the bullet engine. It sits between the accelerometer front end and the `sprite` instance, driving its `sprx`, in the pixel-clock domain.

## Interface
Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SHIP_WIDTH`, 17: sprite width; the rightmost legal `ship_x` is `SCREEN_W-SHIP_WIDTH` (623).
- `X_INIT`, 220: `ship_x` value after reset.
- `DEADZONE`, 16: a tilt whose magnitude is below this value gives step 0.
- `SHIFT`, 4: tilt-to-step arithmetic right shift.
- `MAX_STEP`, 8: step saturation magnitude, in pixels per frame.
- `COOLDOWN`, 15: number of frames after an accepted shot during which fire is ignored.

Ports:
- `clk_pix`, in, 1: pixel clock (25 MHz); every register is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `frame`, in, 1: one-cycle pulse at the start of each frame, from `display_480p`.
- `tilt_x`, in, 12: signed X-axis acceleration; positive means move right.
- `tilt_valid`, in, 1: when high, `tilt_x` is captured.
- `fire`, in, 1: fire button, active-high, already synchronized and debounced.
- `shot_ready`, in, 1: the bullet engine accepts the shot.
- `ship_x`, out, 16: ship left-edge x coordinate.
- `shot_valid`, out, 1: a shot request is pending.
- `shot_x`, out, 16: bullet spawn x; stable while `shot_valid` is high.
- `busy`, out, 1: high when the FSM is not in IDLE.

## Operation
- Tilt latch: `tilt_q <= tilt_x` on any cycle with `tilt_valid` high. The latch operates independently of the FSM.
- The FSM has three states: IDLE, CALC, MOVE.
  - IDLE to CALC when `frame` is high. `frame` is ignored while in CALC or MOVE.
  - CALC: compute `step`, registered, then go to MOVE.
    - If `|tilt_q| < DEADZONE`, `step = 0`.
    - Otherwise `step = tilt_q >>> SHIFT`, an arithmetic shift that floors (-20 gives -2; -400 gives -25).
    - Saturate `step` to [-MAX_STEP, +MAX_STEP].
    - Compute the magnitude in 13 bits so that -2048 is handled.
  - MOVE: `nx = ship_x + step`, computed signed in 17 bits.
    - If `nx < 0`, write 0.
    - If `nx > SCREEN_W-SHIP_WIDTH`, write `SCREEN_W-SHIP_WIDTH`.
    - Otherwise write `nx`.
    - Then go to IDLE.
- Fire edge: `fire_q` registers `fire`, and `fire_edge = fire & ~fire_q`.
  - `fire_q` resets to 1, so a button held through reset does not fire.
- Shot accept: on `fire_edge` with `shot_valid==0` and `cooldown==0`:
  - Set `shot_valid`.
  - Load `shot_x <= ship_x + SHIP_WIDTH/2`, using the current register value (`SHIP_WIDTH/2` is 8).
  - Fire edges that arrive while `shot_valid` is high or `cooldown` is nonzero are dropped, not queued.
- Handshake: the transfer completes on a cycle where `shot_valid && shot_ready`.
  - That edge clears `shot_valid` and loads `cooldown <= COOLDOWN`.
  - `shot_x` holds its value until the next accepted shot.
- Cooldown: decrements by 1 on each `frame` pulse while nonzero, saturating at 0. It counts in every FSM state.
  - If a load and a `frame` pulse occur in the same cycle, the load wins.
- Reset values: `ship_x=X_INIT`, `shot_valid=0`, `shot_x=0`, `busy=0`, state IDLE, `tilt_q=0`, `step=0`, `cooldown=0`.
  - Reset mid-CALC or mid-MOVE abandons the update; `ship_x` returns to `X_INIT`.

## Timing
- Let edge T be the edge that samples `frame=1`.
  - T: state becomes CALC; `busy` goes high after T.
  - T+1: `step` is registered; state becomes MOVE.
  - T+2: `ship_x` is updated; state becomes IDLE; `busy` goes low.
  - Motion latency is therefore 2 cycles after the frame-sampling edge, well inside vertical blanking.
- Tilt used: the `tilt_q` value present at edge T+1. A `tilt_valid` at edge T or earlier is included.
- Fire: `fire` rising, sampled at edge E, gives `shot_valid=1` after E.
  - With `shot_ready` held high, `shot_valid` is high for exactly 1 cycle.
- Same-edge fire and MOVE: `shot_x` is computed from the pre-update `ship_x`.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset deasserted with `fire=1` held -> `ship_x=220`, `shot_valid=0`, `busy=0`, no shot until `fire` toggles.
- Tilt sequence:
  - `tilt_x=+80`, frame -> after 2 edges `ship_x=225`, `busy` high for 2 cycles.
  - `tilt_x=+10`, frame -> `ship_x` stays 225.
  - `tilt_x=-400`, frame -> `ship_x=217` (step saturated to -8).
  - `tilt_x=-20`, frame -> 215.
- Clamp at the edges:
  - Starting from `ship_x=620`, `tilt_x=+200`, frame -> 623; a further frame -> 623.
  - Starting from `ship_x=3`, `tilt_x=-128`, frame -> 0.
  - `tilt_x=-2048`, frame -> stays 0.
- Shot handshake:
  - Fire edge at `ship_x=220` -> `shot_valid=1`, `shot_x=228`.
  - Hold `shot_ready=0` for 5 cycles -> outputs held; a second fire edge during this window is dropped.
  - `shot_ready=1` -> `shot_valid` clears on that edge.
- Cooldown:
  - Fire edges after 1 and after 14 frame pulses -> ignored.
  - Fire edge after the 15th pulse -> accepted.
- Simultaneous events and reset:
  - Fire edge on the MOVE edge (225 to 230) -> `shot_x=233`.
  - Assert `rst` while the FSM is in MOVE -> `ship_x=220`, `busy=0` immediately, with no clock edge needed.
